bch_t2_seq_decoder: RTL

//  Sequential, parametrised double-error-correcting binary BCH decoder over GF(2^M), n = 2^M-1.

---
 rtl/bch_t2_seq_decoder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/bch_t2_seq_decoder.sv
// Serial double-error-correcting binary BCH decoder over GF(2^M), N = 2^M-1.
// Horner syndromes, closed-form t=2 locator, serial Chien search; one word in flight.
module bch_t2_seq_decoder #(
    parameter int                M         = 4,
    parameter logic [M:0]        PRIM_POLY = 5'b10011,
    parameter int                K         = 7,
    parameter logic [2**M-1-K:0] GEN_POLY  = 9'b111010001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2**M-2:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2**M-2:0] out_data,
    output logic [K-1:0]    out_msg,
    output logic [1:0]      out_err_cnt,
    output logic            out_fail,
    output logic [2:0]      dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, and out_* hold steady while out_valid waits for out_ready.

    localparam int N   = 2**M - 1;
    localparam int PAR = $bits(GEN_POLY) - 1;
    localparam logic [M-1:0] GF_ONE   = M'(1);
    localparam logic [M-1:0] CNT_LAST = M'(N - 1);
    localparam logic [M-1:0] CNT_END  = M'(N);

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[M-1] ? ((x << 1) ^ PRIM_POLY[M-1:0]) : (x << 1);
        end
        return acc;
    endfunction

    // a^(2^M-2) = product of a^(2^j), j = 1..M-1; maps 0 to 0.
    function automatic logic [M-1:0] gf_inv(input logic [M-1:0] a);
        logic [M-1:0] sq;
        logic [M-1:0] acc;
        sq  = a;
        acc = GF_ONE;
        for (int j = 1; j < M; j++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    localparam logic [M-1:0] ALPHA1  = M'(2);
    localparam logic [M-1:0] ALPHA3  = gf_mul(gf_mul(ALPHA1, ALPHA1), ALPHA1);
    localparam logic [M-1:0] ALPHA_I1 = gf_inv(ALPHA1);
    localparam logic [M-1:0] ALPHA_I2 = gf_mul(ALPHA_I1, ALPHA_I1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYND  = 3'd1,
        S_SOLVE = 3'd2,
        S_CHIEN = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t         state_q;
    logic [N-1:0]   buf_q, raw_q, out_data_q;
    logic [M-1:0]   s1_q, s3_q, t1_q, t2_q, cnt_q;
    logic [1:0]     roots_q, exp_q, out_err_q;
    logic           fail_q, in_ready_q, out_valid_q, out_fail_q;

    logic [M-1:0]   s1_cube, sig2_calc;
    logic           root_hit, synd_bit;

    always_comb begin
        s1_cube   = gf_mul(gf_mul(s1_q, s1_q), s1_q);
        sig2_calc = gf_mul(s3_q ^ s1_cube, gf_inv(s1_q));
        root_hit  = ((t1_q ^ t2_q) == GF_ONE);
        synd_bit  = buf_q[CNT_LAST - cnt_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            raw_q       <= '0;
            s1_q        <= '0;
            s3_q        <= '0;
            t1_q        <= '0;
            t2_q        <= '0;
            cnt_q       <= '0;
            roots_q     <= '0;
            exp_q       <= '0;
            fail_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= '0;
            out_fail_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        buf_q      <= in_data;
                        raw_q      <= in_data;
                        s1_q       <= '0;
                        s3_q       <= '0;
                        cnt_q      <= '0;
                        roots_q    <= '0;
                        fail_q     <= 1'b0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_SYND;
                    end
                end
                S_SYND: begin
                    s1_q <= gf_mul(s1_q, ALPHA1) ^ {{(M-1){1'b0}}, synd_bit};
                    s3_q <= gf_mul(s3_q, ALPHA3) ^ {{(M-1){1'b0}}, synd_bit};
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_SOLVE;
                    end else begin
                        cnt_q <= cnt_q + GF_ONE;
                    end
                end
                S_SOLVE: begin
                    // Locator 1 + sig1*x + sig2*x^2 is loaded straight into the Chien terms.
                    if (s1_q == '0) begin
                        exp_q  <= 2'd0;
                        fail_q <= (s3_q != '0);
                        t1_q   <= '0;
                        t2_q   <= '0;
                    end else if (s3_q == s1_cube) begin
                        exp_q <= 2'd1;
                        t1_q  <= s1_q;
                        t2_q  <= '0;
                    end else begin
                        exp_q <= 2'd2;
                        t1_q  <= s1_q;
                        t2_q  <= sig2_calc;
                    end
                    state_q <= S_CHIEN;
                end
                S_CHIEN: begin
                    if (cnt_q == CNT_END) begin
                        if (fail_q || (roots_q != exp_q)) begin
                            out_data_q <= raw_q;
                            out_fail_q <= 1'b1;
                            out_err_q  <= 2'd0;
                        end else begin
                            out_data_q <= buf_q;
                            out_fail_q <= 1'b0;
                            out_err_q  <= roots_q;
                        end
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end else begin
                        if (root_hit) begin
                            buf_q[cnt_q] <= ~buf_q[cnt_q];
                            roots_q      <= roots_q + 2'd1;
                        end
                        t1_q  <= gf_mul(t1_q, ALPHA_I1);
                        t2_q  <= gf_mul(t2_q, ALPHA_I2);
                        cnt_q <= cnt_q + GF_ONE;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_msg     = out_data_q[N-1:PAR];
    assign out_err_cnt = out_err_q;
    assign out_fail    = out_fail_q;
    assign dbg_state   = state_q;

endmodule
